out_alu_control_unit: RTL and testbench
=======================================

Name: out_alu_control_unit

Overview:
- Return-path control unit between the ALU result side (adder, multiplier) and FIFO_OUT.
- Mirrors the input-side control unit: accepts results with their IDs over a valid/ready handshake from each ALU unit.
- Buffers one result per unit, arbitrates round-robin, and writes tagged words `{result, id, op}` into FIFO_OUT with single-cycle write-enable pulses.
- Never overflows FIFO_OUT.

Parameters:
- DATA_SIZE, 16, result width (add and mul results are both 16 bit)
- ID_SIZE, 8, transaction ID width
- OPERATION_SIZE, 2, op tag width
- OP_ADD, 2'b01, op tag written for adder results
- OP_MUL, 2'b10, op tag written for multiplier results
- CNT_SIZE, 16, width of the written-results counter
- FIFO_OUT_WIDTH, DATA_SIZE+ID_SIZE+OPERATION_SIZE, FIFO_OUT word width (26)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- a_valid_result  in  1  adder result valid
- a_result  in  DATA_SIZE  adder result
- id_add_res  in  ID_SIZE  ID of adder result
- a_ready_result  out  1  unit can accept an adder result
- m_valid_result  in  1  multiplier result valid
- m_result  in  DATA_SIZE  multiplier result
- id_mul_res  in  ID_SIZE  ID of multiplier result
- m_ready_result  out  1  unit can accept a multiplier result
- full_out  in  1  FIFO_OUT full
- w_en_out  out  1  FIFO_OUT write enable, one-cycle pulse
- fifo_out_data  out  FIFO_OUT_WIDTH  word to FIFO_OUT
- res_cnt  out  CNT_SIZE  total words written, saturating

Behaviour:
- Reset (rst high at a clk edge):
  - Both hold buffers empty; w_en_out=0; fifo_out_data=0; res_cnt=0; last_grant=MUL, so ADD wins the first tie.
  - a_ready_result and m_ready_result are forced 0 while rst is high.
  - Reset mid-operation discards any buffered results and cancels a pending write.
- Hold buffers (one per unit):
  - Each buffer stores result, id and a hold_valid flag.
  - x_ready_result = !hold_valid & !rst, combinational.
  - Capture on x_valid_result & x_ready_result at the clk edge; hold_valid is set afterwards.
  - An ALU unit must keep valid and data stable until ready.
- Grant:
  - grant_ok = !full_out & !w_en_out. After each write there is one idle cycle so that full_out reflects the write before the next decision.
  - If only one hold_valid is set and grant_ok: grant that buffer.
  - If both are set and grant_ok: grant the buffer that is not last_grant, then update last_grant.
  - If grant_ok is 0: no grant; buffers hold their data and ready stays low. There is no data loss.
- Write:
  - On a granted edge, fifo_out_data is loaded with:
    - [1:0] = op tag (OP_ADD or OP_MUL)
    - [ID_SIZE+1:2] = id
    - [FIFO_OUT_WIDTH-1:ID_SIZE+2] = result
  - w_en_out is 1 for exactly one cycle; that buffer's hold_valid clears.
  - fifo_out_data keeps its last value when w_en_out=0.
- Latency:
  - Result captured at edge E0.
  - w_en_out and data are high/valid during E1..E2 when grant_ok.
  - The buffer is ready again after E1, so a new capture is possible at E2 at the earliest (no same-edge refill).
- Simultaneous events:
  - Capture into one buffer and grant of the other buffer on the same edge is allowed.
  - A buffer cannot be captured and granted on the same edge, because a buffer only captures when empty.
- Throughput: at most one write every 2 cycles.
- res_cnt: increments on every w_en_out pulse and saturates at all-ones.
- full_out asserted indefinitely: both buffers fill, both readies stay 0, w_en_out stays 0. Draining resumes the cycle after full_out falls.

Decomposition:
- Shared package holds:
  - OP_ADD and OP_MUL encodings, shared with the input-side control unit
  - DATA_SIZE, ID_SIZE, OPERATION_SIZE, FIFO_OUT_WIDTH
  - word field offsets (OP at 0, ID at 2, DATA at 10)
- Sub-module result_hold_reg: one-entry buffer with valid/ready, load, clear and sync reset. It is instantiated twice (adder and multiplier).
- Arbiter, write register and counter live in the top level.

Test Plan:
- Reset: hold rst for 2 cycles with a_valid_result=1 → a_ready_result=0, w_en_out=0, res_cnt=0; no capture.
- Single add: a_result=16'h1234, id_add_res=8'h05 accepted at E0 → w_en_out pulses one cycle after E1 with fifo_out_data={16'h1234, 8'h05, 2'b01}; res_cnt=1.
- Tie: add (16'h0011, id 8'h01) and mul (16'h00F0, id 8'h02) captured on the same edge → ADD word written first, MUL word 2 cycles later; the next tie is won by ADD again only after a MUL grant.
- Backpressure: full_out=1, then issue add and mul → both readies drop, no w_en_out. Release full_out → both words written in round-robin order, none lost.
- Reset mid-operation: buffer holds a mul result when rst is asserted → no write occurs; after reset, buffers are empty and readies return to 1.
- Counter saturation: preload via 65537 writes, or a CNT_SIZE=4 override with 17 writes → res_cnt stops at all-ones.

Source files
------------

// File: rtl/out_alu_control_unit_pkg.sv
// Shared definitions for the ALU return-path control unit: field widths, op tags and
// the FIFO_OUT word layout.
package out_alu_control_unit_pkg;

  localparam int unsigned DATA_SIZE      = 16;
  localparam int unsigned ID_SIZE        = 8;
  localparam int unsigned OPERATION_SIZE = 2;
  localparam int unsigned FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  localparam int unsigned OP_OFFSET   = 0;
  localparam int unsigned ID_OFFSET   = OPERATION_SIZE;
  localparam int unsigned DATA_OFFSET = OPERATION_SIZE + ID_SIZE;

  // Same encodings as the input-side control unit.
  localparam logic [OPERATION_SIZE-1:0] OP_ADD = 2'b01;
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = 2'b10;

  typedef enum logic {
    SrcAdd = 1'b0,
    SrcMul = 1'b1
  } src_e;

  function automatic logic [FIFO_OUT_WIDTH-1:0] pack_word(
    input logic [DATA_SIZE-1:0]      result,
    input logic [ID_SIZE-1:0]        id,
    input logic [OPERATION_SIZE-1:0] op
  );
    logic [FIFO_OUT_WIDTH-1:0] word;
    word = '0;
    word[OP_OFFSET +: OPERATION_SIZE] = op;
    word[ID_OFFSET +: ID_SIZE]        = id;
    word[DATA_OFFSET +: DATA_SIZE]    = result;
    return word;
  endfunction

endpackage

// File: rtl/out_alu_control_unit_result_hold_reg.sv
// One-entry result buffer with valid/ready capture and an external clear, used once per
// ALU unit on the return path.
module result_hold_reg #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned IdWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] result_i,
  input  logic [IdWidth-1:0]   id_i,
  output logic                 ready_o,
  input  logic                 clear_i,
  output logic                 hold_valid_o,
  output logic [DataWidth-1:0] result_o,
  output logic [IdWidth-1:0]   id_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] result_q;
  logic [IdWidth-1:0]   id_q;
  logic                 load;

  // Only an empty buffer accepts, so load and clear never coincide.
  assign ready_o = ~valid_q & ~rst_i;
  assign load    = valid_i & ready_o;

  always_comb begin
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      id_q     <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        result_q <= result_i;
        id_q     <= id_i;
      end
    end
  end

  assign hold_valid_o = valid_q;
  assign result_o     = result_q;
  assign id_o         = id_q;

endmodule

// File: rtl/out_alu_control_unit.sv
// Return-path control unit: buffers one adder and one multiplier result, arbitrates
// round-robin and writes tagged words into FIFO_OUT without ever overflowing it.
module out_alu_control_unit
  import out_alu_control_unit_pkg::*;
#(
  parameter int unsigned CNT_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid_result,
  input  logic [DATA_SIZE-1:0]      a_result,
  input  logic [ID_SIZE-1:0]        id_add_res,
  output logic                      a_ready_result,
  input  logic                      m_valid_result,
  input  logic [DATA_SIZE-1:0]      m_result,
  input  logic [ID_SIZE-1:0]        id_mul_res,
  output logic                      m_ready_result,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic [CNT_SIZE-1:0]       res_cnt
);

  logic                 a_hold_valid, m_hold_valid;
  logic [DATA_SIZE-1:0] a_hold_result, m_hold_result;
  logic [ID_SIZE-1:0]   a_hold_id, m_hold_id;

  logic grant_ok, grant_add, grant_mul;

  src_e                      last_grant_q, last_grant_d;
  logic                      w_en_q, w_en_d;
  logic [FIFO_OUT_WIDTH-1:0] data_q, data_d;
  logic [CNT_SIZE-1:0]       cnt_q, cnt_d;

  result_hold_reg #(
    .DataWidth (DATA_SIZE),
    .IdWidth   (ID_SIZE)
  ) u_add_hold (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (a_valid_result),
    .result_i     (a_result),
    .id_i         (id_add_res),
    .ready_o      (a_ready_result),
    .clear_i      (grant_add),
    .hold_valid_o (a_hold_valid),
    .result_o     (a_hold_result),
    .id_o         (a_hold_id)
  );

  result_hold_reg #(
    .DataWidth (DATA_SIZE),
    .IdWidth   (ID_SIZE)
  ) u_mul_hold (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (m_valid_result),
    .result_i     (m_result),
    .id_i         (id_mul_res),
    .ready_o      (m_ready_result),
    .clear_i      (grant_mul),
    .hold_valid_o (m_hold_valid),
    .result_o     (m_hold_result),
    .id_o         (m_hold_id)
  );

  // The idle cycle after each write lets full_out catch up before the next decision.
  assign grant_ok = ~full_out & ~w_en_q;

  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    if (grant_ok) begin
      if (a_hold_valid && (!m_hold_valid || last_grant_q == SrcMul)) begin
        grant_add = 1'b1;
      end else if (m_hold_valid) begin
        grant_mul = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    w_en_d       = grant_add | grant_mul;
    data_d       = data_q;
    cnt_d        = cnt_q;
    if (grant_add) begin
      last_grant_d = SrcAdd;
      data_d       = pack_word(a_hold_result, a_hold_id, OP_ADD);
    end else if (grant_mul) begin
      last_grant_d = SrcMul;
      data_d       = pack_word(m_hold_result, m_hold_id, OP_MUL);
    end
    if (w_en_d && cnt_q != {CNT_SIZE{1'b1}}) begin
      cnt_d = cnt_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SrcMul;
      w_en_q       <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      w_en_q       <= w_en_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign w_en_out      = w_en_q;
  assign fifo_out_data = data_q;
  assign res_cnt       = cnt_q;

endmodule

// File: tb/tb_out_alu_control_unit.sv
// Bench for out_alu_control_unit: table of result transactions checked by a scoreboard
// of expected FIFO_OUT words, plus reset, latency, backpressure and saturation sequences.
module tb_out_alu_control_unit;

  typedef struct {
    bit          da;
    logic [15:0] a;
    logic [7:0]  ai;
    bit          dm;
    logic [15:0] m;
    logic [7:0]  mi;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid_result, m_valid_result;
  logic [15:0] a_result, m_result;
  logic [7:0]  id_add_res, id_mul_res;
  logic        a_ready_result, m_ready_result;
  logic        full_out;
  logic        w_en_out;
  logic [25:0] fifo_out_data;
  logic [15:0] res_cnt;

  logic        a_ready_s, m_ready_s, w_en_s;
  logic [25:0] data_s;
  logic [3:0]  res_cnt_s;

  int          total = 0;
  int          bad = 0;
  int          cnt_model = 0;
  bit          model_last = 1'b1;  // 1: multiplier granted last
  logic        prev_wen = 1'b0;
  logic [25:0] exp_q[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  out_alu_control_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid_result (a_valid_result),
    .a_result       (a_result),
    .id_add_res     (id_add_res),
    .a_ready_result (a_ready_result),
    .m_valid_result (m_valid_result),
    .m_result       (m_result),
    .id_mul_res     (id_mul_res),
    .m_ready_result (m_ready_result),
    .full_out       (full_out),
    .w_en_out       (w_en_out),
    .fifo_out_data  (fifo_out_data),
    .res_cnt        (res_cnt)
  );

  out_alu_control_unit #(
    .CNT_SIZE (4)
  ) u_dut_small (
    .clk            (clk),
    .rst            (rst),
    .a_valid_result (a_valid_result),
    .a_result       (a_result),
    .id_add_res     (id_add_res),
    .a_ready_result (a_ready_s),
    .m_valid_result (m_valid_result),
    .m_result       (m_result),
    .id_mul_res     (id_mul_res),
    .m_ready_result (m_ready_s),
    .full_out       (full_out),
    .w_en_out       (w_en_s),
    .fifo_out_data  (data_s),
    .res_cnt        (res_cnt_s)
  );

  function automatic logic [25:0] word_of(input logic [15:0] d, input logic [7:0] id,
                                          input bit is_mul);
    logic [1:0] op;
    op = is_mul ? 2'b10 : 2'b01;
    return {d, id, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write is matched against the oldest expected word.
  always @(negedge clk) begin
    if (w_en_out) begin
      logic [25:0] exp_word;
      check("write_spacing", {31'd0, prev_wen}, 32'd0);
      cnt_model++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %h expected no write", fifo_out_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("word", {6'd0, fifo_out_data}, {6'd0, exp_word});
      end
      check("res_cnt", {16'd0, res_cnt}, (cnt_model > 65535) ? 32'd65535 : cnt_model);
      check("res_cnt_small", {28'd0, res_cnt_s}, (cnt_model > 15) ? 32'd15 : cnt_model);
    end
    prev_wen = w_en_out;
  end

  task automatic send(input vec_t v, input bit push);
    bit a_pend, m_pend, a_fire, m_fire;
    int t;
    a_pend = v.da;
    m_pend = v.dm;
    t = 0;
    if (push) begin
      if (v.da && v.dm) begin
        if (model_last) begin
          exp_q.push_back(word_of(v.a, v.ai, 1'b0));
          exp_q.push_back(word_of(v.m, v.mi, 1'b1));
          model_last = 1'b1;
        end else begin
          exp_q.push_back(word_of(v.m, v.mi, 1'b1));
          exp_q.push_back(word_of(v.a, v.ai, 1'b0));
          model_last = 1'b0;
        end
      end else if (v.da) begin
        exp_q.push_back(word_of(v.a, v.ai, 1'b0));
        model_last = 1'b0;
      end else if (v.dm) begin
        exp_q.push_back(word_of(v.m, v.mi, 1'b1));
        model_last = 1'b1;
      end
    end
    @(negedge clk);
    a_valid_result = v.da;
    a_result       = v.a;
    id_add_res     = v.ai;
    m_valid_result = v.dm;
    m_result       = v.m;
    id_mul_res     = v.mi;
    while ((a_pend || m_pend) && t < 40) begin
      a_fire = a_pend && a_ready_result;
      m_fire = m_pend && m_ready_result;
      @(posedge clk);
      #1;
      if (a_fire) begin
        a_valid_result = 1'b0;
        a_pend = 1'b0;
      end
      if (m_fire) begin
        m_valid_result = 1'b0;
        m_pend = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    a_valid_result = 1'b0;
    m_valid_result = 1'b0;
    check("handshake_done", {30'd0, a_pend, m_pend}, 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0011, 8'h01, 1'b1, 16'h00F0, 8'h02};
    vecs[1] = '{1'b1, 16'h0022, 8'h03, 1'b1, 16'h0044, 8'h04};
    vecs[2] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFFFF, 8'hFF};
    vecs[3] = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00};
    vecs[4] = '{1'b1, 16'h8001, 8'h80, 1'b1, 16'h7FFE, 8'h7F};
    vecs[5] = '{1'b1, 16'hFFFF, 8'hFF, 1'b0, 16'h0000, 8'h00};

    // Reset held two cycles with a pending adder result: nothing may be captured.
    rst = 1'b1;
    full_out = 1'b0;
    a_valid_result = 1'b1;
    a_result = 16'hDEAD;
    id_add_res = 8'h77;
    m_valid_result = 1'b0;
    m_result = '0;
    id_mul_res = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_a_ready", {31'd0, a_ready_result}, 32'd0);
      check("rst_m_ready", {31'd0, m_ready_result}, 32'd0);
      check("rst_wen", {31'd0, w_en_out}, 32'd0);
      check("rst_cnt", {16'd0, res_cnt}, 32'd0);
      check("rst_data", {6'd0, fifo_out_data}, 32'd0);
    end
    rst = 1'b0;
    a_valid_result = 1'b0;
    @(negedge clk);
    check("post_rst_a_ready", {31'd0, a_ready_result}, 32'd1);
    check("post_rst_m_ready", {31'd0, m_ready_result}, 32'd1);

    // Single add with exact latency: captured at E0, written during E1..E2.
    exp_q.push_back(word_of(16'h1234, 8'h05, 1'b0));
    model_last = 1'b0;
    a_valid_result = 1'b1;
    a_result = 16'h1234;
    id_add_res = 8'h05;
    @(posedge clk);
    #1;
    a_valid_result = 1'b0;
    @(negedge clk);
    check("lat_e0_wen", {31'd0, w_en_out}, 32'd0);
    check("lat_e0_ready", {31'd0, a_ready_result}, 32'd0);
    @(negedge clk);
    check("lat_e1_wen", {31'd0, w_en_out}, 32'd1);
    check("lat_e1_ready", {31'd0, a_ready_result}, 32'd1);
    check("lat_e1_data", {6'd0, fifo_out_data}, {6'd0, 26'({16'h1234, 8'h05, 2'b01})});
    check("lat_e1_cnt", {16'd0, res_cnt}, 32'd1);
    @(negedge clk);
    check("lat_pulse_end", {31'd0, w_en_out}, 32'd0);
    check("lat_data_kept", {6'd0, fifo_out_data}, {6'd0, 26'({16'h1234, 8'h05, 2'b01})});

    for (int i = 0; i < 6; i++) begin
      send(vecs[i], 1'b1);
      drain();
    end

    // Backpressure: both buffers fill and hold until full_out falls.
    full_out = 1'b1;
    send('{1'b1, 16'hAAAA, 8'h10, 1'b1, 16'h5555, 8'h11}, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("bp_wen", {31'd0, w_en_out}, 32'd0);
      check("bp_a_ready", {31'd0, a_ready_result}, 32'd0);
      check("bp_m_ready", {31'd0, m_ready_result}, 32'd0);
    end
    full_out = 1'b0;
    drain();

    // Reset while a multiplier result waits: it must be discarded.
    full_out = 1'b1;
    send('{1'b0, 16'h0000, 8'h00, 1'b1, 16'hBEEF, 8'h22}, 1'b0);
    @(negedge clk);
    check("mid_m_held", {31'd0, m_ready_result}, 32'd0);
    rst = 1'b1;
    full_out = 1'b0;
    cnt_model = 0;
    model_last = 1'b1;
    @(negedge clk);
    check("mid_rst_wen", {31'd0, w_en_out}, 32'd0);
    check("mid_rst_m_ready", {31'd0, m_ready_result}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_after_a_ready", {31'd0, a_ready_result}, 32'd1);
    check("mid_after_m_ready", {31'd0, m_ready_result}, 32'd1);
    check("mid_after_cnt", {16'd0, res_cnt}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("mid_no_write", {31'd0, w_en_out}, 32'd0);
    end

    // First tie after reset goes to the adder.
    send('{1'b1, 16'h0101, 8'h31, 1'b1, 16'h0202, 8'h32}, 1'b1);
    drain();

    // Enough writes to saturate the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      send('{1'b1, 16'(i * 16'h0111), 8'(i), 1'b0, 16'h0000, 8'h00}, 1'b1);
      drain();
    end
    check("sat_small", {28'd0, res_cnt_s}, 32'd15);
    check("cnt_wide", {16'd0, res_cnt}, 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
